ahb_timer_sched: RTL and testbench
==================================

AHB_TIMER_SCHED -- requirements
Module: ahb_timer_sched

Interface
REQ-001 SHALL use one clock and one synchronous, active-high reset; all state changes only on rising HCLK.
REQ-002 SHALL provide these ports (clock and reset first):
 HCLK  in  1  system clock
 HRESET  in  1  synchronous active-high reset
 HSEL  in  1  AHB-Lite slave select
 HADDR  in  32  AHB address; only HADDR[5:2] decoded
 HTRANS  in  2  AHB transfer type; HTRANS[1]=1 means active
 HWRITE  in  1  AHB write
 HREADY  in  1  AHB bus ready
 HWDATA  in  32  AHB write data, valid in data phase
 HRDATA  out  32  AHB read data
 HREADYOUT  out  1  slave ready, tied 1 (zero wait states)
 timer_irq  out  1  interrupt, high while any enabled channel is pending
 irq_id  out  2  channel currently granted to timer_irq

Function
REQ-003 SHALL sample HADDR[5:2] and HWRITE when HSEL & HREADY & HTRANS[1] in the address phase, and act on them in the next (data) cycle only.
REQ-004 SHALL decode these register offsets: 0x00 CTRL (bit0 GEN, bit1 PRE, bits[7:4] channel enable mask); 0x04 COUNT (RO); 0x08 PEND (bits[3:0], write-1-to-clear); 0x0C IRQID (bit31 valid, bits[1:0] id, RO); 0x10+8n CMPn; 0x14+8n PERn, for n=0..3.
REQ-005 SHALL drive HRDATA combinationally from the sampled data-phase offset; undefined offsets read 0; writes to RO or undefined offsets are ignored.
REQ-006 SHALL increment the 32-bit COUNT by 1 on every tick while GEN=1, wrapping from 0xFFFFFFFF to 0; a tick is every HCLK unless the prescaler is active (REQ-016).
REQ-007 SHALL arm channel n on any write to CMPn, and disarm it when a one-shot expiry occurs.
REQ-008 SHALL expire channel n on a tick where the channel is armed, enabled and COUNT equals CMPn; expiry sets PEND[n].
REQ-009 SHALL, on expiry with PERn!=0, set CMPn <= CMPn+PERn modulo 2^32 and keep the channel armed; with PERn=0, disarm it (one-shot).
REQ-010 SHALL have a PEND set (expiry) take priority over a same-cycle W1C of the same bit; a same-cycle CMPn write SHALL override the REQ-009 reload.
REQ-011 SHALL grant timer_irq via a round-robin arbiter over PEND & enable mask: when no grant is held and requests exist, grant the first requester after the last-served channel (after reset the first searched is channel 0).
REQ-012 SHALL hold the grant (irq_id, IRQID.id) stable until that PEND bit clears, then advance the last-served pointer to the granted channel and re-arbitrate on the next cycle.
REQ-013 SHALL drive timer_irq = IRQID.valid = grant held; the grant is dropped if its channel's enable bit is cleared.
REQ-014 SHALL stop COUNT and expiries while GEN=0; register access, PEND clearing and arbitration continue.

Reset
REQ-015 SHALL on HRESET=1 set: CTRL=0, COUNT=0, PEND=0, all CMPn=0xFFFFFFFF and disarmed, PERn=0, grant invalid, last-served pointer=3 (so channel 0 is searched first), timer_irq=0, irq_id=0, HRDATA=0, sampled address/write cleared. Reset overrides any same-cycle write.

Configuration
REQ-016 SHALL, with TIMER_SCHED_PRESCALE_EN defined, include a 7-bit prescale counter: when PRE=1, one tick per 128 HCLK. This counter runs only while GEN=1 and is cleared by reset and when GEN=0. Without TIMER_SCHED_PRESCALE_EN, CTRL.PRE SHALL read 0, ignore writes, and a tick occurs every HCLK.

Structure
REQ-017 SHALL place register offsets, CTRL bit positions, NUM_CH=4 and the prescale ratio in package ahb_timer_sched_pkg.
REQ-018 SHALL implement arbitration in one sub-module, rr_arbiter4 (request[3:0], grant-hold and pointer state, grant id/valid out).

Verification
REQ-019 Reset, then read all registers -> CTRL=0, COUNT=0, PEND=0, CMPn=0xFFFFFFFF, IRQID=0, timer_irq=0.
REQ-020 CMP0=10, PER0=0, CTRL=0x11 -> PEND[0]=1 and timer_irq=1 at the tick where COUNT=10; CH0 disarmed; W1C 0x1 -> irq=0, no re-fire after wrap.
REQ-021 CMP1=5, PER1=0xFFFFFFFE -> reload gives CMP1=3 (wrap); the next expiry occurs at COUNT=3 after COUNT wraps past 0xFFFFFFFF.
REQ-022 Channels 0 and 2 expire in the same tick -> irq_id=0 first; clear PEND[0] -> irq_id=2; a later simultaneous 0/2 pend then grants 2 before 0 (round robin).
REQ-023 W1C PEND[3] in the same cycle as its expiry -> PEND[3] stays 1; HRESET asserted mid-count -> all REQ-015 values on the next edge.
REQ-024 With TIMER_SCHED_PRESCALE_EN defined and CTRL=0x13 -> COUNT steps once per 128 HCLK; without it -> CTRL reads 0x11 and COUNT steps every HCLK.

Source files
------------

// File: rtl/ahb_timer_sched_pkg.sv
// Register map, CTRL bit positions and sizing shared by the timer scheduler.
// Pure definitions: no latency, no flow control.
package ahb_timer_sched_pkg;

  localparam int NUM_CH         = 4;
  localparam int PRESCALE_RATIO = 128;
  localparam int PRESCALE_W     = 7;
  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(PRESCALE_RATIO - 1);

  // Byte offsets within the 64-byte window decoded from HADDR[5:2]
  localparam logic [5:0] OFF_CTRL  = 6'h00;
  localparam logic [5:0] OFF_COUNT = 6'h04;
  localparam logic [5:0] OFF_PEND  = 6'h08;
  localparam logic [5:0] OFF_IRQID = 6'h0C;
  localparam logic [5:0] OFF_CMP0  = 6'h10;
  localparam logic [5:0] OFF_PER3  = 6'h2C;

  localparam int CTRL_GEN_BIT = 0;
  localparam int CTRL_PRE_BIT = 1;
  localparam int CTRL_EN_LSB  = 4;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

  function automatic logic is_ch_reg(input logic [5:0] off);
    return (off >= OFF_CMP0) && (off <= OFF_PER3);
  endfunction

  // CMPn sits at 0x10+8n, PERn at 0x14+8n
  function automatic logic [1:0] ch_of(input logic [5:0] off);
    return 2'((off - OFF_CMP0) >> 3);
  endfunction

endpackage

// File: rtl/ahb_timer_sched_arb.sv
// Round-robin grant over four requests; grant registered one cycle after request.
// Grant held until its request drops, then released for one cycle before re-arbitration.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic       grant_vld,
  output logic [1:0] grant_id
);

  logic       vld_q, vld_d;
  logic [1:0] id_q, id_d;
  logic [1:0] last_q, last_d;
  logic [1:0] cand;
  logic       found;

  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    last_d = last_q;
    cand   = '0;
    found  = 1'b0;
    if (vld_q) begin
      if (!req[id_q]) begin
        vld_d  = 1'b0;
        last_d = id_q;
      end
    end else if (|req) begin
      // Search starts one past the last-served channel and wraps back to it
      for (int i = 1; i <= 4; i++) begin
        cand = last_q + 2'(i);
        if (req[cand] && !found) begin
          found = 1'b1;
          vld_d = 1'b1;
          id_d  = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      id_q   <= 2'd0;
      last_q <= 2'd3;
    end else begin
      vld_q  <= vld_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign grant_vld = vld_q;
  assign grant_id  = id_q;

endmodule

// File: rtl/ahb_timer_sched.sv
// AHB-Lite 4-channel compare timer with round-robin IRQ; zero wait states, reads combinational
// in the data phase, never back-pressures. TIMER_SCHED_PRESCALE_EN adds a divide-by-128 tick.
module ahb_timer_sched (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        timer_irq,
  output logic [1:0]  irq_id
);
  import ahb_timer_sched_pkg::*;

  logic [3:0]  addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        act_q, act_d;
  logic        gen_q, gen_d;
  logic [3:0]  en_q, en_d;
  logic [31:0] count_q, count_d;
  logic [3:0]  pend_q, pend_d;
  logic [3:0]  armed_q, armed_d;
  logic [31:0] cmp_q [NUM_CH];
  logic [31:0] cmp_d [NUM_CH];
  logic [31:0] per_q [NUM_CH];
  logic [31:0] per_d [NUM_CH];
  logic        tick;
  logic [3:0]  expire;
  logic        wr_en;
  logic [5:0]  off;
  logic        grant_vld;
  logic [1:0]  grant_id;
  logic        unused_bits;

`ifdef TIMER_SCHED_PRESCALE_EN
  logic                  pre_q, pre_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
`else
  logic                  pre_q;
  assign pre_q = 1'b0;
`endif

  assign unused_bits = ^{HADDR[31:6], HADDR[1:0], HTRANS[0]};
  assign HREADYOUT   = 1'b1;
  assign wr_en       = act_q & wr_q;
  assign off         = {addr_q, 2'b00};

  always_comb begin
    tick = gen_q;
`ifdef TIMER_SCHED_PRESCALE_EN
    presc_d = gen_q ? presc_q + 7'd1 : '0;
    if (pre_q) tick = gen_q && (presc_q == PRESCALE_LAST);
`endif
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++)
      expire[n] = tick && armed_q[n] && en_q[n] && (count_q == cmp_q[n]);
  end

  always_comb begin
    act_d   = HSEL & HREADY & HTRANS[1];
    addr_d  = act_d ? HADDR[5:2] : addr_q;
    wr_d    = act_d ? HWRITE : wr_q;
    gen_d   = gen_q;
    en_d    = en_q;
    count_d = tick ? count_q + 32'd1 : count_q;
    pend_d  = pend_q;
    armed_d = armed_q;
    cmp_d   = cmp_q;
    per_d   = per_q;
`ifdef TIMER_SCHED_PRESCALE_EN
    pre_d   = pre_q;
`endif
    if (wr_en && off == OFF_CTRL) begin
      gen_d = HWDATA[CTRL_GEN_BIT];
      en_d  = HWDATA[CTRL_EN_LSB +: 4];
`ifdef TIMER_SCHED_PRESCALE_EN
      pre_d = HWDATA[CTRL_PRE_BIT];
`endif
    end
    if (wr_en && off == OFF_PEND)
      pend_d = pend_q & ~HWDATA[3:0];
    // Expiry is applied after the W1C so a same-cycle set wins
    for (int n = 0; n < NUM_CH; n++) begin
      if (expire[n]) begin
        pend_d[n] = 1'b1;
        if (per_q[n] != 32'd0) cmp_d[n] = cmp_q[n] + per_q[n];
        else                   armed_d[n] = 1'b0;
      end
    end
    // A bus write to CMPn lands last, overriding any reload in the same cycle
    if (wr_en && is_ch_reg(off)) begin
      if (off[2]) begin
        per_d[ch_of(off)] = HWDATA;
      end else begin
        cmp_d[ch_of(off)]   = HWDATA;
        armed_d[ch_of(off)] = 1'b1;
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (act_q && !wr_q) begin
      if (off == OFF_CTRL)       HRDATA = {24'd0, en_q, 2'b00, pre_q, gen_q};
      else if (off == OFF_COUNT) HRDATA = count_q;
      else if (off == OFF_PEND)  HRDATA = {28'd0, pend_q};
      else if (off == OFF_IRQID) HRDATA = {grant_vld, 29'd0, grant_id};
      else if (is_ch_reg(off))   HRDATA = off[2] ? per_q[ch_of(off)] : cmp_q[ch_of(off)];
    end
  end

  rr_arbiter4 u_arb (
    .clk       (HCLK),
    .rst       (HRESET),
    .req       (pend_q & en_q),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  assign timer_irq = grant_vld;
  assign irq_id    = grant_id;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      act_q   <= 1'b0;
      gen_q   <= 1'b0;
      en_q    <= '0;
      count_q <= '0;
      pend_q  <= '0;
      armed_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        cmp_q[n] <= CMP_RESET;
        per_q[n] <= '0;
      end
    end else begin
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      act_q   <= act_d;
      gen_q   <= gen_d;
      en_q    <= en_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      armed_q <= armed_d;
      cmp_q   <= cmp_d;
      per_q   <= per_d;
    end
  end

`ifdef TIMER_SCHED_PRESCALE_EN
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pre_q   <= 1'b0;
      presc_q <= '0;
    end else begin
      pre_q   <= pre_d;
      presc_q <= presc_d;
    end
  end
`endif

endmodule

// File: tb/tb_ahb_timer_sched.sv
// Directed bench for ahb_timer_sched: bus reads/writes with hand-derived expectations.
module tb_ahb_timer_sched;
  logic        HCLK;
  logic        HRESET, HSEL, HWRITE, HREADY, HREADYOUT, timer_irq;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, irq_id;
  int checks;
  int failures;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_timer_sched dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .timer_irq(timer_irq), .irq_id(irq_id)
  );

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  task automatic wait_irq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge HCLK); #1;
      if (timer_irq === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    idle(2);
    HRESET = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v, exp;
    logic [5:0]  off;
    do_reset;
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL reset_irq_id got=%0d exp=0", irq_id); end
    checks++; if (HRDATA !== 32'd0) begin failures++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
    checks++; if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL hreadyout got=%b exp=1", HREADYOUT); end
    for (int i = 0; i < 13; i++) begin
      off = 6'(i * 4);
      exp = (off >= 6'h10 && off <= 6'h2C && !off[2]) ? 32'hFFFF_FFFF : 32'h0;
      ahb_read({26'd0, off}, v);
      checks++; if (v !== exp) begin failures++; $display("FAIL reset_reg off=%h got=%h exp=%h", off, v, exp); end
    end
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    do_reset;
    ahb_write(32'h10, 32'd10);
    ahb_write(32'h14, 32'd0);
    ahb_write(32'h00, 32'h11);
    // Count reaches 10 eleven edges later; pend and then grant each take one more edge
    idle(11);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL oneshot_early got=%b exp=0", timer_irq); end
    idle(1);
    checks++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL oneshot_fire got=%b exp=1", timer_irq); end
    checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL oneshot_id got=%0d exp=0", irq_id); end
    ahb_read(32'h08, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL oneshot_pend got=%h exp=1", v); end
    ahb_read(32'h0C, v);
    checks++; if (v !== 32'h8000_0000) begin failures++; $display("FAIL oneshot_irqid got=%h exp=80000000", v); end
    ahb_write(32'h08, 32'h1);
    idle(1);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL oneshot_clear got=%b exp=0", timer_irq); end
    ahb_read(32'h0C, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL oneshot_irqid_clr got=%h exp=0", v); end
  endtask

  task automatic test_periodic;
    logic [31:0] v;
    bit ok;
    do_reset;
    ahb_write(32'h18, 32'd5);
    ahb_write(32'h1C, 32'hFFFF_FFFE);
    ahb_write(32'h20, 32'd5);
    ahb_write(32'h24, 32'd20);
    ahb_write(32'h00, 32'h61);
    wait_irq(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL periodic_irq timeout got=0 exp=1"); end
    checks++; if (irq_id !== 2'd1) begin failures++; $display("FAIL periodic_id got=%0d exp=1", irq_id); end
    ahb_read(32'h18, v);
    checks++; if (v !== 32'd3) begin failures++; $display("FAIL cmp1_wrap got=%h exp=3", v); end
    ahb_read(32'h20, v);
    checks++; if (v !== 32'd25) begin failures++; $display("FAIL cmp2_reload got=%0d exp=25", v); end
    ahb_write(32'h08, 32'h6);
    wait_irq(40, ok);
    checks++; if (!ok) begin failures++; $display("FAIL periodic_refire timeout got=0 exp=1"); end
    checks++; if (irq_id !== 2'd2) begin failures++; $display("FAIL periodic_refire_id got=%0d exp=2", irq_id); end
    ahb_read(32'h20, v);
    checks++; if (v !== 32'd45) begin failures++; $display("FAIL cmp2_reload2 got=%0d exp=45", v); end
    ahb_read(32'h08, v);
    checks++; if (v !== 32'h4) begin failures++; $display("FAIL periodic_pend got=%h exp=4", v); end
  endtask

  task automatic test_round_robin;
    logic [31:0] c;
    bit ok;
    do_reset;
    ahb_write(32'h10, 32'd20);
    ahb_write(32'h20, 32'd20);
    ahb_write(32'h00, 32'h51);
    wait_irq(60, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rr_first timeout got=0 exp=1"); end
    checks++; if (irq_id !== 2'd0) begin failures++; $display("FAIL rr_first_id got=%0d exp=0", irq_id); end
    ahb_read(32'h08, c);
    checks++; if (c !== 32'h5) begin failures++; $display("FAIL rr_pend got=%h exp=5", c); end
    ahb_write(32'h08, 32'h1);
    idle(2);
    checks++; if (timer_irq !== 1'b1 || irq_id !== 2'd2) begin failures++; $display("FAIL rr_second got=%b/%0d exp=1/2", timer_irq, irq_id); end
    ahb_write(32'h08, 32'h4);
    idle(1);
    checks++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL rr_idle got=%b exp=0", timer_irq); end
    // Serve channel 0 alone so the pointer rests on 0
    ahb_write(32'h00, 32'h50);
    ahb_read(32'h04, c);
    ahb_write(32'h10, c + 32'd3);
    ahb_write(32'h00, 32'h51);
    wait_irq(30, ok);
    checks++; if (!ok || irq_id !== 2'd0) begin failures++; $display("FAIL rr_solo got=%b/%0d exp=1/0", ok, irq_id); end
    ahb_write(32'h08, 32'h1);
    idle(2);
    ahb_write(32'h00, 32'h50);
    ahb_read(32'h04, c);
    ahb_write(32'h10, c + 32'd3);
    ahb_write(32'h20, c + 32'd3);
    ahb_write(32'h00, 32'h51);
    wait_irq(30, ok);
    checks++; if (!ok || irq_id !== 2'd2) begin failures++; $display("FAIL rr_rotate got=%b/%0d exp=1/2", ok, irq_id); end
    ahb_write(32'h08, 32'h4);
    idle(2);
    checks++; if (timer_irq !== 1'b1 || irq_id !== 2'd0) begin failures++; $display("FAIL rr_rotate_next got=%b/%0d exp=1/0", timer_irq, irq_id); end
  endtask

  task automatic test_cmp_override;
    logic [31:0] v;
    do_reset;
    ahb_write(32'h10, 32'd1);
    ahb_write(32'h14, 32'd100);
    ahb_write(32'h00, 32'h11);
    // This write's data edge is the same edge as the count==1 expiry
    ahb_write(32'h10, 32'd50);
    ahb_read(32'h10, v);
    checks++; if (v !== 32'd50) begin failures++; $display("FAIL cmp_override got=%0d exp=50", v); end
    ahb_read(32'h08, v);
    checks++; if (v !== 32'h1) begin failures++; $display("FAIL cmp_override_pend got=%h exp=1", v); end
  endtask

  task automatic test_w1c_collision_and_reset;
    logic [31:0] v;
    do_reset;
    ahb_write(32'h28, 32'd1);
    ahb_write(32'h00, 32'h81);
    ahb_write(32'h08, 32'h8);
    ahb_read(32'h08, v);
    checks++; if (v !== 32'h8) begin failures++; $display("FAIL w1c_collision got=%h exp=8", v); end
    checks++; if (timer_irq !== 1'b1 || irq_id !== 2'd3) begin failures++; $display("FAIL w1c_irq got=%b/%0d exp=1/3", timer_irq, irq_id); end
    // CTRL write in flight when reset hits: reset must win
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h0;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hF3; HRESET = 1'b1;
    @(posedge HCLK); #1;
    checks++; if (timer_irq !== 1'b0 || irq_id !== 2'd0) begin failures++; $display("FAIL midreset_irq got=%b/%0d exp=0/0", timer_irq, irq_id); end
    checks++; if (HRDATA !== 32'd0) begin failures++; $display("FAIL midreset_hrdata got=%h exp=0", HRDATA); end
    HRESET = 1'b0;
    ahb_read(32'h00, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midreset_ctrl got=%h exp=0", v); end
    ahb_read(32'h04, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midreset_count got=%h exp=0", v); end
    ahb_read(32'h08, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midreset_pend got=%h exp=0", v); end
    ahb_read(32'h28, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL midreset_cmp3 got=%h exp=ffffffff", v); end
    ahb_read(32'h0C, v);
    checks++; if (v !== 32'h0) begin failures++; $display("FAIL midreset_irqid got=%h exp=0", v); end
  endtask

  task automatic test_prescale_gen;
    logic [31:0] c1, c2;
    do_reset;
    ahb_write(32'h00, 32'h13);
    ahb_read(32'h00, c1);
`ifdef TIMER_SCHED_PRESCALE_EN
    checks++; if (c1 !== 32'h13) begin failures++; $display("FAIL pre_ctrl got=%h exp=13", c1); end
    ahb_read(32'h04, c1);
    checks++; if (c1 !== 32'd0) begin failures++; $display("FAIL pre_count0 got=%0d exp=0", c1); end
    idle(130);
    ahb_read(32'h04, c2);
    checks++; if (c2 !== 32'd1) begin failures++; $display("FAIL pre_count1 got=%0d exp=1", c2); end
`else
    checks++; if (c1 !== 32'h11) begin failures++; $display("FAIL pre_ctrl got=%h exp=11", c1); end
    ahb_read(32'h04, c1);
    ahb_read(32'h04, c2);
    checks++; if (c2 !== c1 + 32'd1) begin failures++; $display("FAIL count_step got=%0d exp=%0d", c2, c1 + 32'd1); end
`endif
    ahb_write(32'h00, 32'h10);
    ahb_read(32'h04, c1);
    idle(5);
    ahb_read(32'h04, c2);
    checks++; if (c2 !== c1) begin failures++; $display("FAIL gen_stop got=%0d exp=%0d", c2, c1); end
  endtask

  initial begin
    checks = 0; failures = 0;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    HADDR = 32'd0; HWDATA = 32'd0;
    test_reset;
    test_oneshot;
    test_periodic;
    test_round_robin;
    test_cmp_override;
    test_w1c_collision_and_reset;
    test_prescale_gen;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
